mac_op_sequencer: RTL and testbench

- Parametrised successor to the single-shot top-level MAC launcher.
- Accepts one job over the dut_valid/dut_ready handshake and reads a 2-word dimension header from input SRAM.
- Then launches NUM_OPS back-to-back MAC operations (e.g. Q, K, V projections), each with its own weight-read and result-write base addresses, waiting on MAC completion between launches.
- Sits between the top-level DUT ports and the MAC engine instance.

---
 rtl/mac_seq_pkg.sv | 32 +++
 rtl/mac_seq_addr_gen.sv | 74 +++++++
 rtl/mac_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_mac_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and constants for the MAC operation sequencer
package mac_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_HCAP,
      S_CALC,
      S_LAUNCH,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_e;

   // Header word 0 carries M and K, word 1 carries N
   localparam int M_MSB = 31;
   localparam int M_LSB = 16;
   localparam int K_MSB = 15;
   localparam int K_LSB = 0;
   localparam int N_MSB = 15;
   localparam int N_LSB = 0;

   localparam int HDR0_ADDR = 0;
   localparam int HDR1_ADDR = 1;

   localparam int DEF_NUM_OPS = 3;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_DIM_W   = 16;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// rtl/mac_seq_addr_gen.sv - per-op index counter and weight/result base accumulators
module mac_seq_addr_gen
   import mac_seq_pkg::*;
#(
   parameter int NUM_OPS = DEF_NUM_OPS,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DIM_W   = DEF_DIM_W
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_i,
   input  logic                     advance_i,
   input  logic [DIM_W-1:0]         m_i,
   input  logic [DIM_W-1:0]         k_i,
   input  logic [DIM_W-1:0]         n_i,
   output logic [$clog2(NUM_OPS):0] op_idx_o,
   output logic [ADDR_W-1:0]        weight_base_o,
   output logic [ADDR_W-1:0]        result_base_o,
   output logic                     last_op_o
);

   localparam int IDX_W  = $clog2(NUM_OPS) + 1;
   localparam int PROD_W = 2 * DIM_W;

   logic [PROD_W-1:0] kn_full, mn_full;
   logic [ADDR_W-1:0] kn_q, kn_d, mn_q, mn_d;
   logic [ADDR_W-1:0] wbase_q, wbase_d, rbase_q, rbase_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   assign kn_full = {{DIM_W{1'b0}}, k_i} * {{DIM_W{1'b0}}, n_i};
   assign mn_full = {{DIM_W{1'b0}}, m_i} * {{DIM_W{1'b0}}, n_i};

   // Strides are multiplied once at load; later ops only add, wrapping at ADDR_W
   always_comb begin
      kn_d    = kn_q;
      mn_d    = mn_q;
      wbase_d = wbase_q;
      rbase_d = rbase_q;
      idx_d   = idx_q;
      if (load_i) begin
         kn_d    = ADDR_W'(kn_full);
         mn_d    = ADDR_W'(mn_full);
         wbase_d = '0;
         rbase_d = '0;
         idx_d   = '0;
      end else if (advance_i) begin
         idx_d   = idx_q + IDX_W'(1);
         wbase_d = wbase_q + kn_q;
         rbase_d = rbase_q + mn_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kn_q    <= '0;
         mn_q    <= '0;
         wbase_q <= '0;
         rbase_q <= '0;
         idx_q   <= '0;
      end else begin
         kn_q    <= kn_d;
         mn_q    <= mn_d;
         wbase_q <= wbase_d;
         rbase_q <= rbase_d;
         idx_q   <= idx_d;
      end
   end

   assign op_idx_o      = idx_q;
   assign weight_base_o = wbase_q;
   assign result_base_o = rbase_q;
   assign last_op_o     = (idx_q == IDX_W'(NUM_OPS - 1));

endmodule

// File: rtl/mac_op_sequencer.sv
// rtl/mac_op_sequencer.sv - job sequencer launching NUM_OPS MAC ops; MAC_SEQ_TIMEOUT_EN adds a WAIT watchdog
module mac_op_sequencer
   import mac_seq_pkg::*;
#(
   parameter int NUM_OPS        = DEF_NUM_OPS,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int DIM_W          = DEF_DIM_W,
   parameter int TIMEOUT_CYCLES = 4096
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     dut_valid,
   output logic                     dut_ready,
   output logic [ADDR_W-1:0]        dut__tb__sram_input_read_address,
   input  logic [DATA_W-1:0]        tb__dut__sram_input_read_data,
   output logic                     mac_valid,
   input  logic                     mac_ready,
   output logic [$clog2(NUM_OPS):0] mac_op_idx,
   output logic [ADDR_W-1:0]        mac_weight_base_addr,
   output logic [ADDR_W-1:0]        mac_result_base_addr,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   state_e           state_q, state_d;
   logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
   logic             last_op, ag_load, ag_advance, dims_zero, timeout_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (dut_valid) state_d = S_HDR0;
         S_HDR0:   state_d = S_HDR1;
         S_HDR1:   state_d = S_HCAP;
         S_HCAP:   state_d = S_CALC;
         S_CALC:   state_d = dims_zero ? S_DONE : S_LAUNCH;
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            if (mac_ready)        state_d = S_NEXT;
            else if (timeout_hit) state_d = S_DONE;
         end
         S_NEXT:   state_d = last_op ? S_DONE : S_LAUNCH;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dut_ready  = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      mac_valid  = (state_q == S_LAUNCH);
      done       = (state_q == S_DONE);
      ag_load    = (state_q == S_CALC);
      ag_advance = (state_q == S_NEXT) && !last_op;
      dut__tb__sram_input_read_address = (state_q == S_HDR1) ? ADDR_W'(HDR1_ADDR)
                                                             : ADDR_W'(HDR0_ADDR);
   end

   // Read data lags the address by one cycle, so each word lands one state later
   always_comb begin
      m_d = m_q;
      k_d = k_q;
      n_d = n_q;
      if (state_q == S_HDR1) begin
         m_d = DIM_W'(tb__dut__sram_input_read_data[M_MSB:M_LSB]);
         k_d = DIM_W'(tb__dut__sram_input_read_data[K_MSB:K_LSB]);
      end
      if (state_q == S_HCAP) n_d = DIM_W'(tb__dut__sram_input_read_data[N_MSB:N_LSB]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q <= '0;
         k_q <= '0;
         n_q <= '0;
      end else begin
         m_q <= m_d;
         k_q <= k_d;
         n_q <= n_d;
      end
   end

   assign dims_zero = (m_q == '0) || (k_q == '0) || (n_q == '0);

`ifdef MAC_SEQ_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic             error_q, error_d;

   assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   // WAIT is only entered from LAUNCH, so clearing there restarts the count per op
   always_comb begin
      timer_d = timer_q;
      error_d = error_q;
      if (state_q == S_LAUNCH)    timer_d = '0;
      else if (state_q == S_WAIT) timer_d = timer_q + TMR_W'(1);
      if (state_q == S_IDLE && dut_valid)                         error_d = 1'b0;
      else if (state_q == S_WAIT && !mac_ready && timeout_hit)    error_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q <= '0;
         error_q <= 1'b0;
      end else begin
         timer_q <= timer_d;
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

   mac_seq_addr_gen #(
      .NUM_OPS (NUM_OPS),
      .ADDR_W  (ADDR_W),
      .DIM_W   (DIM_W)
   ) u_addr_gen (
      .clk           (clk),
      .rst_n         (reset_n),
      .load_i        (ag_load),
      .advance_i     (ag_advance),
      .m_i           (m_q),
      .k_i           (k_q),
      .n_i           (n_q),
      .op_idx_o      (mac_op_idx),
      .weight_base_o (mac_weight_base_addr),
      .result_base_o (mac_result_base_addr),
      .last_op_o     (last_op)
   );

endmodule

// File: tb/tb_mac_op_sequencer.sv
// tb/tb_mac_op_sequencer.sv - self-checking bench for mac_op_sequencer (timeout cases with MAC_SEQ_TIMEOUT_EN)
module tb_mac_op_sequencer;

   localparam int NUM_OPS = 3;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 32;
   localparam int DIM_W   = 16;
   localparam int TMO     = 10;
   localparam int NEVER   = 99;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     dut_valid;
   logic                     dut_ready;
   logic [ADDR_W-1:0]        raddr;
   logic [DATA_W-1:0]        rdata;
   logic                     mac_valid;
   logic                     mac_ready;
   logic [$clog2(NUM_OPS):0] mac_op_idx;
   logic [ADDR_W-1:0]        wbase;
   logic [ADDR_W-1:0]        rbase;
   logic                     busy;
   logic                     done;
   logic                     error;

   logic [31:0] hdr0, hdr1;

   always #5 clk = ~clk;

   mac_op_sequencer #(
      .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk                              (clk),
      .reset_n                          (reset_n),
      .dut_valid                        (dut_valid),
      .dut_ready                        (dut_ready),
      .dut__tb__sram_input_read_address (raddr),
      .tb__dut__sram_input_read_data    (rdata),
      .mac_valid                        (mac_valid),
      .mac_ready                        (mac_ready),
      .mac_op_idx                       (mac_op_idx),
      .mac_weight_base_addr             (wbase),
      .mac_result_base_addr             (rbase),
      .busy                             (busy),
      .done                             (done),
      .error                            (error)
   );

   // Input SRAM with one-cycle read latency
   always @(posedge clk)
      rdata <= (raddr == 0) ? hdr0 : (raddr == 1) ? hdr1 : 32'hdead_beef;

   typedef struct {
      int cyc;
      int idx;
      int w;
      int r;
   } launch_t;

   typedef struct {
      int m;
      int k;
      int n;
      int delay;
      int exp_launches;
      int exp_done;
   } vec_t;

   int      checks   = 0;
   int      failures = 0;
   launch_t exp_q[$];
   launch_t got_q[$];
   int      exp_done;
   int      exp_err;
   int      prev_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Timeline from the rules: accept at 0, first launch at 5, ready seen in WAIT
   // at launch+max(delay,1), next launch 2 cycles later, done 2 cycles after last ready
   function automatic void model(input int m, input int k, input int n, input int delay);
      int L, d, mask;
      mask = (1 << ADDR_W) - 1;
      exp_q.delete();
      exp_err = 0;
      if (m == 0 || k == 0 || n == 0) begin
         exp_done = 5;
         return;
      end
      d = (delay < 1) ? 1 : delay;
      L = 5;
      for (int i = 0; i < NUM_OPS; i++) begin
         exp_q.push_back('{L, i, (i * k * n) & mask, (i * m * n) & mask});
`ifdef MAC_SEQ_TIMEOUT_EN
         if (d > TMO) begin
            exp_done = L + TMO + 1;
            exp_err  = 1;
            return;
         end
`endif
         if (i == NUM_OPS - 1) exp_done = L + d + 2;
         else                  L = L + d + 2;
      end
   endfunction

   // delay < 0: mac_ready held high throughout; delay >= NEVER: never returned
   function automatic logic ready_for(input int delay, input bit launched, input int c, input int last_l);
      if (delay < 0)      return 1'b1;
      if (delay >= NEVER) return 1'b0;
      return launched && (c >= last_l + delay);
   endfunction

   task automatic run_job(input int m, input int k, input int n, input int delay,
                          input int tab_launch, input int tab_done, input string tag);
      int   c, last_l, done_c, n_exp;
      bit   launched, seen_done;
      logic got_err;
      model(m, k, n, delay);
      got_q.delete();
      launched  = 0;
      seen_done = 0;
      last_l    = 0;
      done_c    = -1;
      got_err   = 1'b0;
      @(negedge clk);
      hdr0 = {m[15:0], k[15:0]};
      hdr1 = {16'h0, n[15:0]};
      check({tag, " ready_idle"}, dut_ready, 1);
      check({tag, " err_sticky"}, error, prev_err);
      dut_valid = 1'b1;
      mac_ready = (delay < 0);
      c = 0;
      while (!seen_done && c < 300) begin
         @(negedge clk);
         c++;
         dut_valid = 1'b0;
         if (c == 1) begin
            check({tag, " busy_c1"}, busy, 1);
            check({tag, " ready_c1"}, dut_ready, 0);
            check({tag, " err_clr_c1"}, error, 0);
            check({tag, " addr_c1"}, raddr, 0);
         end
         if (c == 2) check({tag, " addr_c2"}, raddr, 1);
         if (mac_valid) begin
            got_q.push_back('{c, int'(mac_op_idx), int'(wbase), int'(rbase)});
            launched = 1;
            last_l   = c;
         end
         if (done) begin
            seen_done = 1;
            done_c    = c;
            got_err   = error;
         end
         mac_ready = ready_for(delay, launched, c, last_l);
      end
      if (!seen_done) begin
         failures++;
         checks++;
         $display("FAIL %s done_wait actual=none expected=cycle %0d", tag, exp_done);
      end
      @(negedge clk);
      mac_ready = 1'b0;
      check({tag, " ready_after"}, dut_ready, 1);
      check({tag, " done_1cyc"}, done, 0);
      n_exp = (tab_launch >= 0) ? tab_launch : exp_q.size();
      check({tag, " n_launch"}, got_q.size(), n_exp);
      check({tag, " done_cyc"}, done_c, (tab_done >= 0) ? tab_done : exp_done);
      check({tag, " err_done"}, got_err, exp_err);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s l%0d cyc", tag, i), got_q[i].cyc, exp_q[i].cyc);
         check($sformatf("%s l%0d idx", tag, i), got_q[i].idx, exp_q[i].idx);
         check($sformatf("%s l%0d wbase", tag, i), got_q[i].w, exp_q[i].w);
         check($sformatf("%s l%0d rbase", tag, i), got_q[i].r, exp_q[i].r);
      end
      prev_err = exp_err;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " dut_ready"}, dut_ready, 1);
      check({tag, " busy"}, busy, 0);
      check({tag, " mac_valid"}, mac_valid, 0);
      check({tag, " done"}, done, 0);
      check({tag, " error"}, error, 0);
      check({tag, " idx"}, mac_op_idx, 0);
      check({tag, " wbase"}, wbase, 0);
      check({tag, " rbase"}, rbase, 0);
      check({tag, " raddr"}, raddr, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      vec_t tab[$];
      int   c, extra_v, extra_d, m, k, n, d;

      reset_n   = 1'b0;
      dut_valid = 1'b0;
      mac_ready = 1'b0;
      hdr0      = '0;
      hdr1      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;

      tab.push_back('{4, 8, 2, 3, 3, 20});
      tab.push_back('{4, 8, 0, 3, 0, 5});
      tab.push_back('{0, 8, 2, 3, 0, 5});
      tab.push_back('{4, 0, 2, 3, 0, 5});
      tab.push_back('{4, 8, 2, -1, 3, 14});
      tab.push_back('{16, 16, 1, 1, 3, 14});
      tab.push_back('{16, 16, 16, 2, 3, 17});
`ifdef MAC_SEQ_TIMEOUT_EN
      tab.push_back('{4, 8, 2, NEVER, 1, 16});
      tab.push_back('{2, 2, 2, 10, 3, 41});
      tab.push_back('{2, 2, 2, 11, 1, 16});
      tab.push_back('{3, 3, 3, 2, 3, 17});
`endif
      for (int i = 0; i < tab.size(); i++)
         run_job(tab[i].m, tab[i].k, tab[i].n, tab[i].delay,
                 tab[i].exp_launches, tab[i].exp_done, $sformatf("vec%0d", i));

      // Reset during WAIT of op 1: nothing may continue afterwards
      @(negedge clk);
      hdr0 = {16'd4, 16'd8};
      hdr1 = {16'h0, 16'd2};
      dut_valid = 1'b1;
      c = 0;
      while (c < 11) begin
         @(negedge clk);
         c++;
         dut_valid = 1'b0;
         mac_ready = 1'b0;
         if (c == 8) mac_ready = 1'b1;
      end
      check("midrst busy_before", busy, 1);
      check("midrst idx_before", mac_op_idx, 1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset_n   = 1'b1;
      mac_ready = 1'b1;
      extra_v   = 0;
      extra_d   = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (mac_valid) extra_v++;
         if (done) extra_d++;
      end
      mac_ready = 1'b0;
      check("midrst no_launch", extra_v, 0);
      check("midrst no_done", extra_d, 0);
      check("midrst idle", dut_ready, 1);
      prev_err = 0;
      run_job(4, 8, 2, 3, 3, 20, "after_rst");

      for (int i = 0; i < 20; i++) begin
         m = $urandom_range(0, 20);
         k = $urandom_range(0, 20);
         n = $urandom_range(0, 20);
`ifdef MAC_SEQ_TIMEOUT_EN
         d = $urandom_range(0, 12);
`else
         d = $urandom_range(0, 6);
`endif
         if (d == 0) d = -1;
         run_job(m, k, n, d, -1, -1, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
